// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the manager bridge state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR
    } bridge_state_t;

endpackage

// File: rtl/ahb_size_encoder.sv
// Maps a byte-lane mask to HSIZE and the byte offset within the data bus.
module ahb_size_encoder
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int NB = DATA_WIDTH / 8,
    localparam int LB = $clog2(NB)
) (
    input  logic [NB-1:0] byte_en,
    output logic [2:0]    hsize,
    output logic [LB-1:0] offset
);

    localparam logic [2:0] FULL_SIZE = (NB == 8) ? HSIZE_DWORD : HSIZE_WORD;

    logic [NB-1:0] pat;

    // Try every naturally aligned run of 1, 2 or 4 lanes narrower than the bus;
    // anything that matches none of them stays full width.
    always_comb begin
        hsize  = FULL_SIZE;
        offset = '0;
        pat    = '0;
        for (int unsigned s = 0; s < 3; s++) begin
            for (int unsigned i = 0; i < NB; i++) begin
                for (int unsigned j = 0; j < NB; j++) begin
                    pat[j] = (j >= i) && (j < i + (32'd1 << s));
                end
                if (((32'd1 << s) < NB) && ((i % (32'd1 << s)) == 0) && (byte_en == pat)) begin
                    hsize  = (s == 0) ? HSIZE_BYTE : (s == 1) ? HSIZE_HALF : HSIZE_WORD;
                    offset = LB'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_lite_manager_bridge.sv
// Generic single-transfer request port to AHB-Lite manager, NONSEQ only,
// with registered data phase and two-cycle ERROR handling.
module ahb_lite_manager_bridge
    import ahb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011,
    localparam int         NB         = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [NB-1:0]         byte_en,
    input  logic                  ren,
    input  logic                  wen,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic                  HSEL,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic [NB-1:0]         HWSTRB,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int LB = $clog2(NB);

    bridge_state_t         state, state_nxt;
    htrans_t               trans;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]         strb_q;
    logic                  write_q;
    logic [2:0]            enc_size;
    logic [LB-1:0]         enc_off;
    logic                  addr_phase, accept, req_write;
    logic                  unused_addr_bits;

    ahb_size_encoder #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .byte_en (byte_en),
        .hsize   (enc_size),
        .offset  (enc_off)
    );

    assign req_write  = wen & ~ren;
    assign addr_phase = (state == ST_IDLE) && (ren || wen) && nRST;
    assign accept     = addr_phase && HREADY;

    // Request low address bits are replaced by the lane offset from the mask.
    assign unused_addr_bits = ^addr[LB-1:0];
    assign HADDR     = {addr[ADDR_WIDTH-1:LB], enc_off};
    assign HSIZE     = enc_size;
    assign HWRITE    = addr_phase & req_write;
    assign HTRANS    = trans;
    assign HSEL      = trans[1];
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = wdata_q;
    assign HWSTRB    = write_q ? strb_q : '0;
    assign rdata     = HRDATA;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_DATA;
            ST_DATA: begin
                if (HRESP == HRESP_ERROR) state_nxt = ST_ERR;
                else if (HREADY)          state_nxt = ST_IDLE;
            end
            ST_ERR:  if (HREADY) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        trans = HTRANS_IDLE;
        busy  = 1'b1;
        error = 1'b0;
        case (state)
            ST_IDLE: if (addr_phase) trans = HTRANS_NONSEQ;
            ST_DATA: if (HREADY && (HRESP == HRESP_OKAY)) busy = 1'b0;
            ST_ERR: begin
                if (HREADY) begin
                    busy  = 1'b0;
                    error = 1'b1;
                end
            end
            default: trans = HTRANS_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            wdata_q <= wdata;
            strb_q  <= byte_en;
            write_q <= req_write;
        end
    end

endmodule
